ff_bank_sched: RTL and testbench

//  Sequencer/arbiter sharing one WIDTH-bit FLIPFLOP bank (data/clk/preset/clear per bit)

---
 rtl/ff_bank_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_ff_bank_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_sched.sv
// ---------------------------------------------------------------------------
// ff_bank_sched
//
// Shares one WIDTH-bit flip-flop bank (data/clk/preset/clear per bit) between
// NREQ requesters. A round-robin arbiter grants one requester at a time. Each
// operation runs IDLE -> SETUP -> STROBE (STROBE_CYC cycles) -> HOLD -> IDLE,
// so data is stable around the strobe. The bank's q outputs come back in. They
// are used to form the TOGGLE value and, optionally, to read the result back.
//
// Parameters
//   WIDTH       bank width in bits (>=1)
//   NREQ        number of requesters (2..8)
//   STROBE_CYC  cycles that the active strobe stays high (>=1)
//
// Ports
//   clk        in   system clock, all logic on posedge
//   clear      in   synchronous active-low reset
//   req        in   [NREQ]        level request per requester, held until done
//   op         in   [2*NREQ]      op[2i+1:2i]: 00 LOAD, 01 SET, 10 CLR, 11 TOGGLE
//   wdata      in   [WIDTH*NREQ]  load data, slice i belongs to requester i
//   q          in   [WIDTH]       bank q outputs
//   gnt        out  [NREQ]        one-hot grant, SETUP through HOLD
//   done       out  [NREQ]        one-cycle completion pulse (HOLD)
//   busy       out                high whenever not IDLE
//   ff_data    out  [WIDTH]       bank data pins
//   ff_clk     out                bank clock strobe (LOAD/TOGGLE)
//   ff_preset  out                bank preset strobe (SET)
//   ff_clear   out                bank clear strobe (CLR)
//
// Optional feature: define FF_BANK_SCHED_READBACK_EN to add
//   err        out                sticky readback mismatch flag
//   rdata      out  [WIDTH]       q captured in HOLD
// ---------------------------------------------------------------------------
module ff_bank_sched #(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int STROBE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [WIDTH*NREQ-1:0]  wdata,
    input  logic [WIDTH-1:0]       q,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   busy,
    output logic [WIDTH-1:0]       ff_data,
    output logic                   ff_clk,
    output logic                   ff_preset,
    output logic                   ff_clear
`ifdef FF_BANK_SCHED_READBACK_EN
    ,
    output logic                   err,
    output logic [WIDTH-1:0]       rdata
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLR    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [PW-1:0]    rr_ptr, rr_n;
    logic [PW-1:0]    gidx, gidx_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] val_q, val_n;
    logic [NREQ-1:0]  gnt_n, done_n;
    logic [WIDTH-1:0] data_n;
    logic [2:0]       strb_n;

    logic             found;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_wd;

    // Strobe pattern {ff_clk, ff_preset, ff_clear} for an operation.
    function automatic logic [2:0] strobe_for(input logic [1:0] o);
        case (o)
            OP_SET:  strobe_for = 3'b010;
            OP_CLR:  strobe_for = 3'b001;
            default: strobe_for = 3'b100;
        endcase
    endfunction

    // LOAD and TOGGLE present their value on the data pins; SET/CLR drive 0.
    function automatic logic drives_data(input logic [1:0] o);
        drives_data = (o == OP_LOAD) || (o == OP_TOGGLE);
    endfunction

    // Round-robin: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Operand slices of the selected requester.
    always_comb begin
        sel_op = '0;
        sel_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == PW'(i)) begin
                sel_op = op[2*i +: 2];
                sel_wd = wdata[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rr_n    = rr_ptr;
        gidx_n  = gidx;
        op_n    = op_q;
        val_n   = val_q;
        gnt_n   = gnt;
        done_n  = '0;
        data_n  = ff_data;
        strb_n  = 3'b000;

        case (state)
            IDLE: begin
                gnt_n  = '0;
                data_n = '0;
                if (found) begin
                    gidx_n  = pick;
                    op_n    = sel_op;
                    // TOGGLE takes its value from the bank as it is right now.
                    val_n   = (sel_op == OP_TOGGLE) ? ~q : sel_wd;
                    gnt_n   = NREQ'(1) << pick;
                    data_n  = drives_data(sel_op) ? val_n : '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                cnt_n   = '0;
                strb_n  = strobe_for(op_q);
                state_n = STROBE;
            end
            STROBE: begin
                if (cnt == CW'(STROBE_CYC - 1)) begin
                    done_n  = NREQ'(1) << gidx;
                    state_n = HOLD;
                end else begin
                    cnt_n  = cnt + 1'b1;
                    strb_n = strobe_for(op_q);
                end
            end
            HOLD: begin
                gnt_n   = '0;
                data_n  = '0;
                rr_n    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Control and pin registers: every strobe comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            gidx      <= '0;
            gnt       <= '0;
            done      <= '0;
            ff_data   <= '0;
            ff_clk    <= 1'b0;
            ff_preset <= 1'b0;
            ff_clear  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rr_ptr    <= rr_n;
            gidx      <= gidx_n;
            gnt       <= gnt_n;
            done      <= done_n;
            ff_data   <= data_n;
            {ff_clk, ff_preset, ff_clear} <= strb_n;
        end
    end

    // Captured operand, only meaningful while an op is in flight.
    always_ff @(posedge clk) begin
        op_q  <= op_n;
        val_q <= val_n;
    end

    assign busy = (state != IDLE);

`ifdef FF_BANK_SCHED_READBACK_EN
    logic [WIDTH-1:0] expect_q;

    always_comb begin
        case (op_q)
            OP_SET:  expect_q = '1;
            OP_CLR:  expect_q = '0;
            default: expect_q = val_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            err   <= 1'b0;
            rdata <= '0;
        end else if (state == HOLD) begin
            rdata <= q;
            if (q != expect_q)
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ff_bank_sched.sv
module tb_ff_bank_sched;

    localparam int SC = 1;
    localparam logic [1:0] LD = 2'b00;
    localparam logic [1:0] ST = 2'b01;
    localparam logic [1:0] CL = 2'b10;
    localparam logic [1:0] TG = 2'b11;

    logic        tbclk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] wdata;
    logic [7:0]  q;
    logic [3:0]  gnt, done;
    logic        busy;
    logic [7:0]  ff_data;
    logic        ff_clk, ff_preset, ff_clear;
`ifdef FF_BANK_SCHED_READBACK_EN
    logic        err;
    logic [7:0]  rdata;
`endif

    // Behavioural flip-flop bank driven by the scheduler's pins.
    logic [7:0]  bq = 8'h00;
    logic        force_q = 1'b0;

    always @(posedge ff_clk or posedge ff_preset or posedge ff_clear) begin
        if (ff_clear)       bq <= 8'h00;
        else if (ff_preset) bq <= 8'hFF;
        else                bq <= ff_data;
    end
    assign q = force_q ? 8'h00 : bq;

    always #5 tbclk = ~tbclk;

    ff_bank_sched #(.WIDTH(8), .NREQ(4), .STROBE_CYC(SC)) dut (
        .clk       (tbclk),
        .clear     (clear),
        .req       (req),
        .op        (op),
        .wdata     (wdata),
        .q         (q),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .ff_data   (ff_data),
        .ff_clk    (ff_clk),
        .ff_preset (ff_preset),
        .ff_clear  (ff_clear)
`ifdef FF_BANK_SCHED_READBACK_EN
        ,
        .err       (err),
        .rdata     (rdata)
`endif
    );

    int         checks = 0;
    int         failures = 0;
    int         rr_m = 0;        // reference round-robin pointer
    logic [7:0] mq = 8'h00;      // reference bank contents
    logic [7:0] exp_rd = 8'h00;  // reference readback register
    logic       exp_err = 1'b0;  // reference sticky error

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tbclk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Everything idle: no grant, no strobe, data pins low.
    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"},  {28'd0, gnt}, 32'd0);
        chk({tag, "_done"}, {28'd0, done}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_strb"}, {29'd0, ff_clk, ff_preset, ff_clear}, 32'd0);
        chk({tag, "_data"}, {24'd0, ff_data}, 32'd0);
`ifdef FF_BANK_SCHED_READBACK_EN
        chk({tag, "_rdata"}, {24'd0, rdata}, {24'd0, exp_rd});
        chk({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
`endif
    endtask

    task automatic idle_step(input string tag);
        step();
        chk_quiet(tag);
    endtask

    // Called in an IDLE cycle whose inputs select requester g with op o.
    // v is the value the bank must hold afterwards.
    task automatic expect_op(input string tag, input int g, input logic [1:0] o,
                             input logic [7:0] v, input bit scramble, input bit chk_q);
        logic [7:0] dexp;
        logic [2:0] sx;
        logic [3:0] gx;
        dexp = (o == LD || o == TG) ? v : 8'h00;
        sx   = (o == ST) ? 3'b010 : (o == CL) ? 3'b001 : 3'b100;
        gx   = 4'b0001 << g;

        step();
        chk({tag, "_setup_gnt"},  {28'd0, gnt}, {28'd0, gx});
        chk({tag, "_setup_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_setup_data"}, {24'd0, ff_data}, {24'd0, dexp});
        chk({tag, "_setup_strb"}, {29'd0, ff_clk, ff_preset, ff_clear}, 32'd0);
        chk({tag, "_setup_done"}, {28'd0, done}, 32'd0);
        if (scramble) begin
            op    = 8'($urandom);
            wdata = $urandom;
            req   = 4'($urandom);
        end

        for (int s = 0; s < SC; s++) begin
            step();
            chk({tag, "_strobe"},      {29'd0, ff_clk, ff_preset, ff_clear}, {29'd0, sx});
            chk({tag, "_strobe_data"}, {24'd0, ff_data}, {24'd0, dexp});
            chk({tag, "_strobe_gnt"},  {28'd0, gnt}, {28'd0, gx});
            chk({tag, "_strobe_done"}, {28'd0, done}, 32'd0);
        end

        step();
        chk({tag, "_hold_done"}, {28'd0, done}, {28'd0, gx});
        chk({tag, "_hold_gnt"},  {28'd0, gnt}, {28'd0, gx});
        chk({tag, "_hold_strb"}, {29'd0, ff_clk, ff_preset, ff_clear}, 32'd0);
        chk({tag, "_hold_data"}, {24'd0, ff_data}, {24'd0, dexp});
        chk({tag, "_hold_busy"}, {31'd0, busy}, 32'd1);
        if (chk_q) begin
            chk({tag, "_bank_q"}, {24'd0, q}, {24'd0, v});
            exp_rd = v;
        end
        mq   = v;
        rr_m = (g + 1) % 4;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        req   = 4'b0000;
        step();
        exp_rd  = 8'h00;
        exp_err = 1'b0;
        chk_quiet("reset");
        step();
        clear = 1'b1;
        rr_m  = 0;
    endtask

    initial begin
        int         g;
        logic [1:0] o;
        logic [7:0] v;

        // Reset hold with every requester asking.
        clear = 1'b0;
        req   = 4'b1111;
        op    = 8'h00;
        wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) idle_step("rst_hold");

        // Single LOAD A5 from requester 2, released straight out of reset.
        clear = 1'b1;
        req   = 4'b0100;
        op    = 8'h00;
        wdata = 32'h00A5_0000;
        expect_op("load_a5", 2, LD, 8'hA5, 1'b0, 1'b1);
        idle_step("load_a5_idle");

        // All requesters held: grants rotate 0,1,2,3,0, one per 3+SC cycles.
        do_reset();
        req   = 4'b1111;
        op    = 8'h00;
        wdata = 32'h4433_2211;
        for (int n = 0; n < 5; n++) begin
            g = pick(req, rr_m);
            expect_op("rr", g, LD, wdata[8*g +: 8], 1'b0, 1'b1);
            idle_step("rr_idle");
        end

        // SET, CLR, TOGGLE from requester 1.
        req = 4'b0010;
        op  = {4'b0000, ST, 2'b00};
        expect_op("set", 1, ST, 8'hFF, 1'b0, 1'b1);
        idle_step("set_idle");
        op  = {4'b0000, CL, 2'b00};
        expect_op("clr", 1, CL, 8'h00, 1'b0, 1'b1);
        idle_step("clr_idle");
        op  = {4'b0000, TG, 2'b00};
        expect_op("tog", 1, TG, ~mq, 1'b0, 1'b1);
        idle_step("tog_idle");

        // Reset during the strobe of a LOAD: abandoned, pointer back to 0.
        req   = 4'b0001;
        op    = 8'h00;
        wdata = 32'h0000_005A;
        step();
        chk("abort_setup_gnt", {28'd0, gnt}, 32'd1);
        step();
        chk("abort_strobe", {29'd0, ff_clk, ff_preset, ff_clear}, 32'd4);
        clear = 1'b0;
        step();
        exp_rd  = 8'h00;
        exp_err = 1'b0;
        chk_quiet("abort");
        mq    = 8'h5A;   // the clock edge already reached the bank
        clear = 1'b1;
        rr_m  = 0;
        req   = 4'b1010;
        op    = 8'h00;
        wdata = 32'hD400_B200;
        expect_op("after_abort", pick(req, rr_m), LD, 8'hB2, 1'b0, 1'b1);
        idle_step("after_abort_idle");

        // Randomised traffic with mid-op input changes.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'b0000;
                idle_step("rand_noreq");
            end
            req   = 4'($urandom_range(1, 15));
            op    = 8'($urandom);
            wdata = $urandom;
            g = pick(req, rr_m);
            o = op[2*g +: 2];
            case (o)
                LD:      v = wdata[8*g +: 8];
                ST:      v = 8'hFF;
                CL:      v = 8'h00;
                default: v = ~mq;
            endcase
            expect_op("rand", g, o, v, 1'b1, 1'b1);
            idle_step("rand_idle");
        end

`ifdef FF_BANK_SCHED_READBACK_EN
        // Readback mismatch: q pinned to 0 while loading 3C.
        req     = 4'b0001;
        op      = 8'h00;
        wdata   = 32'h0000_003C;
        force_q = 1'b1;
        expect_op("rb_bad", pick(req, rr_m), LD, 8'h3C, 1'b0, 1'b0);
        exp_rd  = 8'h00;
        exp_err = 1'b1;
        idle_step("rb_bad_idle");
        force_q = 1'b0;
        req     = 4'b0001;
        wdata   = 32'h0000_0077;
        expect_op("rb_good", pick(req, rr_m), LD, 8'h77, 1'b0, 1'b1);
        idle_step("rb_sticky");
        do_reset();
        idle_step("rb_cleared");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
